counter_cmd_seq: RTL
====================

Name: counter_cmd_seq

Overview:
- Upstream command sequencer for counter4b. Accepts queued counter commands over a valid/ready interface and drives counter4b's ENABLE/RESET/MODO/D for a programmed number of cycles.
- Monitors the counter's RCO and LOAD outputs, counts overflows and flags LOAD mismatches.
- Sits between the test/control logic and counter4b in parte C.

Parameters:
DEPTH, 4, command FIFO entries (power of two, >=2)
CNT_W, 8, width of the per-command cycle count CMD_LEN

Ports:
CLK  in  1  main clock, rising edge
RESET  in  1  asynchronous, active-low reset
CMD_VALID  in  1  command offered
CMD_READY  out  1  FIFO can accept; equals !full, registered-state only (no combinational path from CMD_VALID)
CMD_MODO  in  2  counter mode (`CUENTA_MAS_UNO, `CUENTA_MENOS_UNO, `CUENTA_TRES_TRES, `CARGA_D)
CMD_D  in  4  load value, used with `CARGA_D
CMD_LEN  in  CNT_W  cycles to keep counter enabled; 0 treated as 1
ABORT  in  1  synchronous flush
C_ENABLE  out  1  to counter4b ENABLE
C_RESET  out  1  to counter4b RESET; always driven 0
C_MODO  out  2  to counter4b MODO
C_D  out  4  to counter4b D
C_RCO  in  1  from counter4b RCO
C_LOAD  in  1  from counter4b LOAD
BUSY  out  1  high in RUN
DONE  out  1  one-cycle pulse per completed command
OVF_CNT  out  8  saturating count of C_RCO pulses since reset
ERR  out  1  sticky LOAD-mismatch flag

Behaviour:
- Reset (RESET=0, async): FIFO empty, state IDLE.
  - C_ENABLE=0, C_RESET=0, C_MODO=0, C_D=0, BUSY=0, DONE=0, OVF_CNT=0, ERR=0.
  - CMD_READY=1 one cycle after RESET deasserts.
- All outputs are registered.
- Push: CMD_VALID && CMD_READY at a rising edge writes {MODO, D, LEN} to the FIFO tail.
- States: IDLE, RUN.
  - IDLE: C_ENABLE=0. Counter4b therefore clears Q to 0.
  - IDLE with FIFO non-empty at an edge: pop the head, load C_MODO/C_D, set rem=max(LEN,1), C_ENABLE=1, go to RUN.
  - Latency: command accepted at edge k -> C_ENABLE=1 after edge k+1 -> first counter update at edge k+2.
  - RUN: each edge decrements rem.
  - RUN with rem==1 and FIFO non-empty: pop the next command in the same edge and stay in RUN. C_ENABLE stays high with no gap.
  - RUN with rem==1 and FIFO empty: go to IDLE, C_ENABLE=0.
- DONE:
  - Pulses for one cycle, one cycle after the last enabled cycle of each command, i.e. aligned with the counter's registered result of that cycle.
  - Back-to-back commands give consecutive DONE pulses, one per command.
- Push when FIFO is empty and state is IDLE: the entry is stored and then popped on the next edge. There is no bypass path.
- Simultaneous push and pop: both are allowed while not full. Occupancy is unchanged.
- Full: CMD_READY=0, the push is ignored, and the upstream holds CMD_VALID.
- ABORT=1 at an edge:
  - FIFO flushed, state IDLE, C_ENABLE=0 on that edge.
  - A push in the same cycle is dropped.
  - No DONE for the aborted command.
  - OVF_CNT and ERR are kept.
- OVF_CNT: increments on each cycle with C_RCO=1 and saturates at 8'hFF.
- Pointer and occupancy widths: log2(DEPTH) pointers plus a separate occupancy counter of width log2(DEPTH)+1.
- Async reset mid-RUN: immediate return to reset values. Queued commands are lost.

Optional Feature:
- Macro: CNT_SEQ_LOAD_CHECK_EN.
- Defined:
  - Register exp_load = C_ENABLE && C_MODO==`CARGA_D, delayed one cycle.
  - Any cycle with C_LOAD != exp_load sets ERR=1. ERR is sticky until RESET.
- Not defined: ERR is tied 0 and no checker logic is built.

Test Plan:
1. Push {`CARGA_D, D=4'hC, LEN=1} then {`CUENTA_MAS_UNO, LEN=5} on consecutive cycles -> C_ENABLE high 6 consecutive cycles, counter Q = C,D,E,F,0,1, OVF_CNT=1, two DONE pulses, BUSY falls after the 6th cycle.
2. LEN=0 with `CUENTA_MENOS_UNO from Q=0 -> exactly 1 enabled cycle, Q=F, RCO=1, OVF_CNT=1, one DONE.
3. Push a LEN=20 command, then hold CMD_VALID with further commands -> DEPTH(4) more accepted, CMD_READY=0 until the running command finishes. The next pop re-asserts CMD_READY the following cycle. No command is lost or duplicated.
4. ABORT at the 3rd cycle of a LEN=10 run with 3 queued -> next edge C_ENABLE=0, BUSY=0, CMD_READY=1, no DONE, queued commands never execute.
5. Drive RESET=0 mid-RUN for 2 cycles -> all outputs 0 immediately, OVF_CNT=0. After release, a new command runs normally.
6. With CNT_SEQ_LOAD_CHECK_EN, run `CARGA_D LEN=2 and force C_LOAD=0 on the expected cycle -> ERR=1 and stays 1 through later clean commands. Without the macro, ERR stays 0.

Source files
------------

// File: rtl/counter_cmd_seq.sv
// Command sequencer for counter4b: queues {MODO, D, LEN} commands and drives the counter's enable for LEN cycles.
// Optional macro CNT_SEQ_LOAD_CHECK_EN builds the LOAD-mismatch checker behind ERR.
`ifndef CUENTA_MAS_UNO
`define CUENTA_MAS_UNO   2'b00
`endif
`ifndef CUENTA_MENOS_UNO
`define CUENTA_MENOS_UNO 2'b01
`endif
`ifndef CUENTA_TRES_TRES
`define CUENTA_TRES_TRES 2'b10
`endif
`ifndef CARGA_D
`define CARGA_D          2'b11
`endif

module counter_cmd_seq #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [1:0]       CMD_MODO,
  input  logic [3:0]       CMD_D,
  input  logic [CNT_W-1:0] CMD_LEN,
  input  logic             ABORT,
  output logic             C_ENABLE,
  output logic             C_RESET,
  output logic [1:0]       C_MODO,
  output logic [3:0]       C_D,
  input  logic             C_RCO,
  input  logic             C_LOAD,
  output logic             BUSY,
  output logic             DONE,
  output logic [7:0]       OVF_CNT,
  output logic             ERR
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 6 + CNT_W;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [EW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count, count_next;
  logic [0:0]       state;
  logic [CNT_W-1:0] rem;
  logic             push, pop, empty, last_cycle;
  logic [EW-1:0]    head;
  logic [CNT_W-1:0] head_len;

  always_comb begin
    empty      = (count == '0);
    last_cycle = (state == RUN) && (rem == CNT_W'(1));
    push       = CMD_VALID && CMD_READY && !ABORT;
    pop        = !ABORT && !empty && ((state == IDLE) || last_cycle);
    head       = mem[rd_ptr];
    head_len   = (head[CNT_W-1:0] == '0) ? CNT_W'(1) : head[CNT_W-1:0];
    count_next = ABORT ? '0 : count + (AW+1)'(push) - (AW+1)'(pop);
  end

  // Storage carries no reset; only the pointers and occupancy define validity.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= {CMD_MODO, CMD_D, CMD_LEN};
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      CMD_READY <= 1'b0;
      state     <= IDLE;
      rem       <= '0;
      C_ENABLE  <= 1'b0;
      C_MODO    <= 2'b00;
      C_D       <= 4'h0;
      DONE      <= 1'b0;
      OVF_CNT   <= 8'h00;
    end else begin
      count     <= count_next;
      CMD_READY <= (count_next != FULL_CNT);
      if (C_RCO && OVF_CNT != 8'hFF) OVF_CNT <= OVF_CNT + 8'h01;
      if (ABORT) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        state    <= IDLE;
        rem      <= '0;
        C_ENABLE <= 1'b0;
        DONE     <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        DONE <= last_cycle;
        // Popping on the final cycle keeps C_ENABLE high with no idle gap.
        if (pop) begin
          C_MODO   <= head[EW-1 -: 2];
          C_D      <= head[CNT_W +: 4];
          rem      <= head_len;
          state    <= RUN;
          C_ENABLE <= 1'b1;
        end else if (state == RUN) begin
          rem <= rem - CNT_W'(1);
          if (last_cycle) begin
            state    <= IDLE;
            C_ENABLE <= 1'b0;
          end
        end
      end
    end
  end

  assign BUSY    = (state == RUN);
  assign C_RESET = 1'b0;

`ifdef CNT_SEQ_LOAD_CHECK_EN
  logic exp_load;

  // LOAD from counter4b lags the enabled CARGA_D cycle by one edge.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      exp_load <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      exp_load <= C_ENABLE && (C_MODO == `CARGA_D);
      if (C_LOAD != exp_load) ERR <= 1'b1;
    end
  end
`else
  logic load_unused;
  assign load_unused = C_LOAD;
  assign ERR = 1'b0;
`endif

endmodule
